// File: rtl/vsd_multi_timer_if.sv
// rtl/vsd_multi_timer_if.sv - register bus interface for vsd_multi_timer
interface vsd_multi_timer_if;
    logic        sel;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output sel, we, addr, wdata, input rdata);
    modport slave  (input sel, we, addr, wdata, output rdata);
endinterface

// File: rtl/vsd_multi_timer.sv
// rtl/vsd_multi_timer.sv - multi-channel down-counting timer with register bus
// Optional prescaler enabled by defining VSD_TIMER_PRESCALER_EN.
module vsd_multi_timer #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              resetn,
    vsd_multi_timer_if.slave  bus,
    output logic [NUM_CH-1:0] timeout,
    output logic              irq
);
    logic                         wr;
    logic                         tick;
    logic [NUM_CH-1:0]            en_v, mode_v, irq_en_v, flag_v;
    logic [NUM_CH-1:0][CNT_W-1:0] load_v, value_v;
    logic                         unused_bits;

    assign wr          = bus.sel && bus.we;
    assign unused_bits = ^{bus.addr[31:7], bus.wdata};

`ifdef VSD_TIMER_PRESCALER_EN
    logic [15:0] presc_q;
    logic [15:0] presc_cnt;
    logic        wr_presc;

    assign wr_presc = wr && (bus.addr[6:0] == 7'h40);
    assign tick     = (presc_cnt == presc_q);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            presc_q   <= '0;
            presc_cnt <= '0;
        end else if (wr_presc) begin
            presc_q   <= bus.wdata[15:0];
            presc_cnt <= '0;
        end else begin
            presc_cnt <= tick ? 16'h0000 : presc_cnt + 16'h0001;
        end
    end
`else
    assign tick = 1'b1;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic             en_q, mode_q, irq_en_q, flag_q, timeout_q;
        logic [CNT_W-1:0] load_q, value_q;
        logic             hit, wr_ctrl, wr_load, wr_stat, expire;

        assign hit     = wr && (bus.addr[6:4] == 3'(g));
        assign wr_ctrl = hit && (bus.addr[3:0] == 4'h0);
        assign wr_load = hit && (bus.addr[3:0] == 4'h4);
        assign wr_stat = hit && (bus.addr[3:0] == 4'hC);
        assign expire  = tick && en_q && (value_q == '0);

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                en_q      <= 1'b0;
                mode_q    <= 1'b0;
                irq_en_q  <= 1'b0;
                flag_q    <= 1'b0;
                timeout_q <= 1'b0;
                load_q    <= '0;
                value_q   <= '0;
            end else begin
                timeout_q <= expire;
                // Expiry sets the flag even when a W1C lands on the same edge
                if (expire)
                    flag_q <= 1'b1;
                else if (wr_stat && bus.wdata[0])
                    flag_q <= 1'b0;
                if (wr_load)
                    load_q <= bus.wdata[CNT_W-1:0];
                // A CTRL write overrides the one-shot auto-disable
                if (wr_ctrl) begin
                    en_q     <= bus.wdata[0];
                    mode_q   <= bus.wdata[1];
                    irq_en_q <= bus.wdata[2];
                end else if (expire && !mode_q) begin
                    en_q <= 1'b0;
                end
                if (wr_ctrl && !en_q && bus.wdata[0])
                    value_q <= load_q;
                else if (expire)
                    value_q <= mode_q ? load_q : '0;
                else if (tick && en_q)
                    value_q <= value_q - 1'b1;
            end
        end

        assign en_v[g]     = en_q;
        assign mode_v[g]   = mode_q;
        assign irq_en_v[g] = irq_en_q;
        assign flag_v[g]   = flag_q;
        assign load_v[g]   = load_q;
        assign value_v[g]  = value_q;
        assign timeout[g]  = timeout_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            irq <= 1'b0;
        else
            irq <= |(flag_v & irq_en_v);
    end

    always_comb begin
        bus.rdata = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            if (bus.addr[6:4] == 3'(n)) begin
                case (bus.addr[3:0])
                    4'h0:    bus.rdata = {29'd0, irq_en_v[n], mode_v[n], en_v[n]};
                    4'h4:    bus.rdata = 32'(load_v[n]);
                    4'h8:    bus.rdata = 32'(value_v[n]);
                    4'hC:    bus.rdata = {31'd0, flag_v[n]};
                    default: bus.rdata = '0;
                endcase
            end
        end
`ifdef VSD_TIMER_PRESCALER_EN
        if (bus.addr[6:0] == 7'h40)
            bus.rdata = {16'd0, presc_q};
`endif
    end
endmodule
